// File: rtl/vigna_bus_arbiter.sv
// Purpose: merge the vigna instruction (i_*) and data (d_*) buses onto one shared memory port (m_*).
// Latency: request sampled in IDLE drives a registered m_valid on the next cycle; completion is returned combinationally.
// Backpressure: the grant is held until m_ready; the losing master waits with ready=0. VIGNA_BUS_ARBITER_ROUND_ROBIN_EN selects round-robin.
module vigna_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,

    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    state_t              state;
    state_t              state_nxt;
    grant_t              grant;
    grant_t              grant_nxt;

    logic                m_valid_nxt;
    logic [ADDR_W-1:0]   m_addr_nxt;
    logic [DATA_W-1:0]   m_wdata_nxt;
    logic [STRB_W-1:0]   m_wstrb_nxt;

    // Tie-break preference when both masters request in the same IDLE cycle.
    logic                prefer_d;
    // Data master wins arbitration this cycle.
    logic                pick_d;
    // The slave completes the granted transaction in this cycle.
    logic                xfer_done;

    // Completion is only recognised while a transaction is actually outstanding;
    // a reset cycle swallows it so an abandoned transaction never reports ready.
    assign xfer_done = resetn && (state == BUSY) && m_valid && m_ready;

`ifdef VIGNA_BUS_ARBITER_ROUND_ROBIN_EN
    // High when the most recently completed transaction belonged to the data master.
    logic last_grant_d;

    // Remember who was served last so the other master wins the next tie.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant_d <= 1'b0;
        end else if (xfer_done) begin
            last_grant_d <= (grant == GNT_D);
        end
    end

    assign prefer_d = !last_grant_d;
`else
    // Fixed priority: loads/stores always beat fetches on a tie.
    assign prefer_d = 1'b1;
`endif

    // A lone requester always wins; on a tie the preference decides.
    assign pick_d = d_valid && (!i_valid || prefer_d);

    // Next-state and next-register values for the shared-port request.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        m_valid_nxt = m_valid;
        m_addr_nxt  = m_addr;
        m_wdata_nxt = m_wdata;
        m_wstrb_nxt = m_wstrb;

        unique case (state)
            IDLE: begin
                if (i_valid || d_valid) begin
                    state_nxt   = BUSY;
                    m_valid_nxt = 1'b1;
                    if (pick_d) begin
                        grant_nxt   = GNT_D;
                        m_addr_nxt  = d_addr;
                        m_wdata_nxt = d_wdata;
                        m_wstrb_nxt = d_wstrb;
                    end else begin
                        // Fetches are always reads: no store data, no strobes.
                        grant_nxt   = GNT_I;
                        m_addr_nxt  = i_addr;
                        m_wdata_nxt = '0;
                        m_wstrb_nxt = '0;
                    end
                end
            end
            BUSY: begin
                // Request stays frozen until the slave answers; master-side
                // changes are ignored for the life of the transaction.
                if (m_ready) begin
                    state_nxt   = IDLE;
                    grant_nxt   = GNT_NONE;
                    m_valid_nxt = 1'b0;
                    m_wstrb_nxt = '0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                grant_nxt   = GNT_NONE;
                m_valid_nxt = 1'b0;
                m_wstrb_nxt = '0;
            end
        endcase
    end

    // State, grant and registered shared-port request.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            grant   <= GNT_NONE;
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            m_valid <= m_valid_nxt;
            m_addr  <= m_addr_nxt;
            m_wdata <= m_wdata_nxt;
            m_wstrb <= m_wstrb_nxt;
        end
    end

    // Steer the slave response to the granted master only.
    always_comb begin
        i_ready = 1'b0;
        d_ready = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
        if (grant == GNT_I) begin
            i_ready = xfer_done;
            i_rdata = m_rdata;
        end
        if (grant == GNT_D) begin
            d_ready = xfer_done;
            d_rdata = m_rdata;
        end
    end

endmodule
